// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: default field widths and flit layout.
// A flit is {addr, data} with the destination address in the MSBs.
package noc_pkg;

   localparam int DefDataWidth = 32;
   localparam int DefAddrWidth = 3;

   typedef struct packed {
      logic [DefAddrWidth-1:0] addr;
      logic [DefDataWidth-1:0] data;
   } flit_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_picker.sv
// Rotating-priority picker: first asserted request at or after i_ptr, wrapping.
// Purely combinational; the pointer itself lives in the caller.
module rr_picker
   import noc_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int off = 0; off < N; off++) begin
         j = int'(i_ptr) + off;
         if (j >= N) j = j - N;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin N:1 flit arbiter with a single registered output stage.
// Holds the rotating pointer, the output flit register and the transfer counter.
module noc_port_arbiter
   import noc_pkg::*;
#(
   parameter  int NumIn      = 4,
   parameter  int DataWidth  = DefDataWidth,
   parameter  int AddrWidth  = DefAddrWidth,
   localparam int TotalWidth = DataWidth + AddrWidth,
   localparam int IdxWidth   = idx_width(NumIn)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NumIn*TotalWidth-1:0] i_data,
   input  logic [NumIn-1:0]            i_valid,
   output logic [NumIn-1:0]            o_ready,
   output logic [TotalWidth-1:0]       o_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [NumIn-1:0]            o_grant,
   output logic [31:0]                 o_pkt_count
);

   logic [IdxWidth-1:0]   r_ptr;
   logic [TotalWidth-1:0] r_data;
   logic                  r_valid;
   logic [NumIn-1:0]      r_grant;
   logic [31:0]           r_pkt_count;

   logic [NumIn-1:0]      w_pick;
   logic [IdxWidth-1:0]   w_idx;
   logic                  w_any;
   logic                  w_load_en;
   logic                  w_accept;
   logic                  w_drain;
   logic [TotalWidth-1:0] w_flit;
   logic [IdxWidth-1:0]   w_ptr_next;

   rr_picker #(
      .N  (NumIn),
      .IW (IdxWidth)
   ) u_picker (
      .i_req   (i_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // The output slot can take a new flit when empty or when it is leaving now.
   assign w_load_en  = !r_valid || i_ready;
   assign w_accept   = w_load_en && w_any && !rst;
   assign w_drain    = r_valid && i_ready;
   assign w_flit     = i_data[int'(w_idx)*TotalWidth +: TotalWidth];
   assign w_ptr_next = (int'(w_idx) == NumIn - 1) ? '0 : w_idx + 1'b1;

   assign o_ready     = w_accept ? w_pick : '0;
   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_grant     = r_grant;
   assign o_pkt_count = r_pkt_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_grant     <= '0;
         r_pkt_count <= '0;
      end else begin
         if (w_drain) begin
            r_pkt_count <= r_pkt_count + 32'd1;
         end
         if (w_accept) begin
            r_data  <= w_flit;
            r_grant <= w_pick;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_next;
         end else if (i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule
